// File: rtl/tdc_pkg.sv
// Shared types and event-word layout for the TDC readout controller.
// The TDC_TIMESTAMP_EN macro widens the event word by a 32-bit timestamp.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    MEASURE,
    SETTLE,
    CAPTURE
  } tdc_state_e;

  localparam int FINE_W_DEF   = 5;
  localparam int COARSE_W_DEF = 48;

`ifdef TDC_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif

  function automatic int ev_width(input int fine_w, input int coarse_w);
    return TS_W + 1 + 2 * fine_w + coarse_w;
  endfunction

  localparam int EV_W_DEF = ev_width(FINE_W_DEF, COARSE_W_DEF);

  // Field offsets of the default event word {ts, timeout, start, stop, count}
  localparam int EV_COUNT_LSB   = 0;
  localparam int EV_STOP_LSB    = COARSE_W_DEF;
  localparam int EV_START_LSB   = COARSE_W_DEF + FINE_W_DEF;
  localparam int EV_TIMEOUT_BIT = COARSE_W_DEF + 2 * FINE_W_DEF;
  localparam int EV_TS_LSB      = EV_TIMEOUT_BIT + 1;

endpackage

// File: rtl/tdc_event_fifo.sv
// Synchronous event FIFO; the empty flag is registered and drives the stream valid.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module tdc_event_fifo #(
  parameter int W     = 59,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/tdc_readout_ctrl.sv
// Arms the TDC, tracks each hit pulse, captures the TDC outputs into an event FIFO.
// Define TDC_TIMESTAMP_EN to prepend a 32-bit cycle timestamp to every event.
module tdc_readout_ctrl
  import tdc_pkg::*;
#(
  parameter int  FINE_W     = FINE_W_DEF,
  parameter int  COARSE_W   = COARSE_W_DEF,
  parameter int  FIFO_DEPTH = 4,
  parameter int  SETTLE_CYC = 3,
  parameter int  MAX_WIDTH  = 1000,
  localparam int EV_W       = ev_width(FINE_W, COARSE_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm_req,
  input  logic                disarm,
  input  logic                cfg_continuous,
  input  logic                hit_in,
  output logic                tdc_gate,
  input  logic [FINE_W-1:0]   tdc_start_bin,
  input  logic [FINE_W-1:0]   tdc_stop_bin,
  input  logic [COARSE_W-1:0] tdc_count,
  output logic [EV_W-1:0]     ev_data,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic                busy,
  output logic [15:0]         drop_cnt
);
  localparam int WC_W = $clog2(MAX_WIDTH + 1);

  tdc_state_e      state;
  logic            hit_s1, hit_s2, hit_s3;
  logic            hit_rise, hit_fall;
  logic [WC_W-1:0] wcnt;
  logic [3:0]      scnt;
  logic            timeout;
  logic            fifo_full, fifo_empty;
  logic            ev_rd;
  logic [EV_W-1:0] ev_word;

  assign hit_rise = hit_s2 & ~hit_s3;
  assign hit_fall = ~hit_s2 & hit_s3;
  assign ev_valid = ~fifo_empty;
  assign ev_rd    = ev_valid & ev_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_s1 <= 1'b0;
      hit_s2 <= 1'b0;
      hit_s3 <= 1'b0;
    end else begin
      hit_s1 <= hit_in;
      hit_s2 <= hit_s1;
      hit_s3 <= hit_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tdc_gate <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      wcnt     <= '0;
      scnt     <= '0;
    end else if (disarm && state != CAPTURE) begin
      state    <= IDLE;
      tdc_gate <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (arm_req) begin
          state    <= ARMED;
          tdc_gate <= 1'b1;
          busy     <= 1'b1;
        end
        ARMED: if (hit_rise) begin
          state <= MEASURE;
          wcnt  <= '0;
        end
        MEASURE: begin
          wcnt <= wcnt + 1'b1;
          // A falling edge in the final allowed cycle still counts as a clean pulse
          if (hit_fall) begin
            state    <= SETTLE;
            timeout  <= 1'b0;
            tdc_gate <= 1'b0;
            scnt     <= 4'(SETTLE_CYC - 1);
          end else if (wcnt == WC_W'(MAX_WIDTH - 1)) begin
            state    <= SETTLE;
            timeout  <= 1'b1;
            tdc_gate <= 1'b0;
            scnt     <= 4'(SETTLE_CYC - 1);
          end
        end
        SETTLE: begin
          if (scnt == '0) state <= CAPTURE;
          else            scnt  <= scnt - 1'b1;
        end
        CAPTURE: begin
          if (cfg_continuous && !disarm) begin
            state    <= ARMED;
            tdc_gate <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state    <= IDLE;
            tdc_gate <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tdc_gate <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef TDC_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (state == ARMED && hit_rise && !disarm) ts_lat <= ts_cnt;
    end
  end

  assign ev_word = {ts_lat, timeout, tdc_start_bin, tdc_stop_bin, tdc_count};
`else
  assign ev_word = {timeout, tdc_start_bin, tdc_stop_bin, tdc_count};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (state == CAPTURE && fifo_full && !ev_rd && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  tdc_event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (state == CAPTURE),
    .wr_data (ev_word),
    .rd_en   (ev_ready),
    .rd_data (ev_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
